// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock generator: FSM states and board constants.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        IDLE_HI,
        RUN,
        STEP_LO,
        STEP_HI
    } clk_state_t;

    // Debounce length for the real push-button at the board sysclk rate.
    localparam int unsigned DEB_CYCLES_BOARD = 500000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 20
) (
    input  logic sysclk,
    input  logic reset,
    input  logic btn,
    output logic btn_db
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync;
    logic             btn_s;
    logic [CNT_W-1:0] dcnt;

    assign btn_s = sync[1];

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], btn};
        end
    end

    // The counter only advances while the synchronised level disagrees with the accepted one.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            btn_db <= 1'b0;
            dcnt   <= '0;
        end else if (btn_s == btn_db) begin
            dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
            btn_db <= btn_s;
            dcnt   <= '0;
        end else begin
            dcnt <= dcnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/step_clk_gen.sv
// CPU clock generator: free-running divided clock or one period per debounced button press.
module step_clk_gen
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DIV_HALF   = 3,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 20
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        run_mode,
    input  logic        step_btn,
    output logic        clk,
    output logic        step_ack,
    output logic [31:0] cycle_cnt
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV_HALF - 1);

    clk_state_t       state, state_nxt;
    logic [1:0]       run_sync;
    logic             run_s;
    logic             btn_db, btn_db_q, step_req;
    logic [CNT_W-1:0] pcnt, pcnt_nxt;
    logic             pcnt_last;
    logic             clk_nxt, ack_nxt;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_btn_debounce (
        .sysclk (sysclk),
        .reset  (reset),
        .btn    (step_btn),
        .btn_db (btn_db)
    );

    assign run_s     = run_sync[1];
    assign step_req  = btn_db & ~btn_db_q;
    assign pcnt_last = (pcnt == HALF_LAST);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state     <= IDLE_HI;
            run_sync  <= '0;
            btn_db_q  <= 1'b0;
            pcnt      <= '0;
            clk       <= 1'b1;
            step_ack  <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state     <= state_nxt;
            run_sync  <= {run_sync[0], run_mode};
            btn_db_q  <= btn_db;
            pcnt      <= pcnt_nxt;
            clk       <= clk_nxt;
            step_ack  <= ack_nxt;
            if (clk_nxt && !clk) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE_HI: begin
                if (run_s) begin
                    state_nxt = RUN;
                end else if (step_req) begin
                    state_nxt = STEP_LO;
                end
            end
            // Run mode is only left at the end of a completed high phase.
            RUN:     if (pcnt_last && clk && !run_s) state_nxt = IDLE_HI;
            STEP_LO: if (pcnt_last) state_nxt = STEP_HI;
            STEP_HI: if (pcnt_last) state_nxt = IDLE_HI;
            default: state_nxt = IDLE_HI;
        endcase
    end

    always_comb begin
        clk_nxt  = clk;
        pcnt_nxt = pcnt;
        ack_nxt  = 1'b0;
        case (state)
            IDLE_HI: begin
                clk_nxt  = 1'b1;
                pcnt_nxt = '0;
                if (!run_s && step_req) begin
                    clk_nxt = 1'b0;
                    ack_nxt = 1'b1;
                end
            end
            RUN: begin
                if (pcnt_last) begin
                    pcnt_nxt = '0;
                    if (!clk) begin
                        clk_nxt = 1'b1;
                    end else if (run_s) begin
                        clk_nxt = 1'b0;
                    end
                end else begin
                    pcnt_nxt = pcnt + CNT_W'(1);
                end
            end
            STEP_LO: begin
                if (pcnt_last) begin
                    pcnt_nxt = '0;
                    clk_nxt  = 1'b1;
                end else begin
                    pcnt_nxt = pcnt + CNT_W'(1);
                end
            end
            STEP_HI: begin
                clk_nxt = 1'b1;
                if (pcnt_last) begin
                    pcnt_nxt = '0;
                end else begin
                    pcnt_nxt = pcnt + CNT_W'(1);
                end
            end
            default: begin
                clk_nxt  = 1'b1;
                pcnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_step_clk_gen.sv
// Scoreboard bench for step_clk_gen: expected clk/step_ack events queued by stimulus, checked by a monitor.
module tb_step_clk_gen;

    typedef struct {
        int unsigned cyc;
        logic        clk;
        logic        ack;
        logic [31:0] cnt;
    } ev_t;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic        run_mode = 1'b0;
    logic        step_btn = 1'b0;
    logic        clk, step_ack;
    logic [31:0] cycle_cnt;

    logic        s_run_mode = 1'b0;
    logic        s_step_btn = 1'b0;
    logic        s_clk, s_ack;
    logic [31:0] s_cycle_cnt;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned obs_rises = 0;
    int unsigned s_acks = 0;
    int unsigned s_rises = 0;
    logic        prev_clk = 1'b1;
    logic        s_prev = 1'b1;
    logic [31:0] exp_cnt = '0;
    int unsigned base;
    int unsigned a0, r0;
    ev_t         exp_q[$];

    step_clk_gen #(
        .DIV_HALF   (3),
        .DEB_CYCLES (4),
        .CNT_W      (20)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .run_mode  (run_mode),
        .step_btn  (step_btn),
        .clk       (clk),
        .step_ack  (step_ack),
        .cycle_cnt (cycle_cnt)
    );

    // Longer half-period so a second press can land inside STEP_HI.
    step_clk_gen #(
        .DIV_HALF   (8),
        .DEB_CYCLES (4),
        .CNT_W      (20)
    ) dut_slow (
        .sysclk    (sysclk),
        .reset     (reset),
        .run_mode  (s_run_mode),
        .step_btn  (s_step_btn),
        .clk       (s_clk),
        .step_ack  (s_ack),
        .cycle_cnt (s_cycle_cnt)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int unsigned c, input logic k, input logic a, input logic [31:0] n);
        ev_t e;
        e.cyc = c;
        e.clk = k;
        e.ack = a;
        e.cnt = n;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge sysclk);
    endtask

    // Monitor: any clk transition or step_ack pulse is an event to match against the queue.
    always @(negedge sysclk) begin
        ev_t e;
        if (reset) begin
            prev_clk = clk;
        end else begin
            if (clk !== prev_clk || step_ack !== 1'b0) begin
                if (clk === 1'b1 && prev_clk === 1'b0) obs_rises++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got cyc=%0d clk=%0b ack=%0b cnt=%0d expected none",
                             cyc, clk, step_ack, cycle_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.clk !== clk || e.ack !== step_ack || e.cnt !== cycle_cnt) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d clk=%0b ack=%0b cnt=%0d expected cyc=%0d clk=%0b ack=%0b cnt=%0d",
                                 cyc, clk, step_ack, cycle_cnt, e.cyc, e.clk, e.ack, e.cnt);
                    end
                end
            end
            prev_clk = clk;
        end
    end

    always @(negedge sysclk) begin
        if (!reset) begin
            if (s_ack === 1'b1) s_acks++;
            if (s_clk === 1'b1 && s_prev === 1'b0) s_rises++;
        end
        s_prev = s_clk;
    end

    task automatic clean_press();
        base = cyc + 1;
        step_btn = 1'b1;
        push_ev(base + 6, 1'b0, 1'b1, exp_cnt);
        exp_cnt++;
        push_ev(base + 9, 1'b1, 1'b0, exp_cnt);
        tick(20);
        step_btn = 1'b0;
        tick(20);
        check("clean_clk_high", {31'd0, clk}, 32'd1);
        check("clean_cnt", cycle_cnt, exp_cnt);
    endtask

    initial begin
        logic [7:0] pat;

        // Reset state and idle hold
        tick(3);
        check("rst_clk", {31'd0, clk}, 32'd1);
        check("rst_cnt", cycle_cnt, 32'd0);
        check("rst_ack", {31'd0, step_ack}, 32'd0);
        reset = 1'b0;
        tick(100);
        check("idle_clk", {31'd0, clk}, 32'd1);
        check("idle_cnt", cycle_cnt, 32'd0);

        clean_press();

        // Bouncy press: 2-cycle glitches, steady high from edge 8
        pat = 8'b0011_0011;
        base = cyc + 1;
        push_ev(base + 14, 1'b0, 1'b1, exp_cnt);
        exp_cnt++;
        push_ev(base + 17, 1'b1, 1'b0, exp_cnt);
        for (int i = 0; i < 8; i++) begin
            step_btn = pat[i];
            tick(1);
        end
        step_btn = 1'b1;
        tick(20);
        pat = 8'b1100_1100;
        for (int i = 0; i < 8; i++) begin
            step_btn = pat[i];
            tick(1);
        end
        step_btn = 1'b0;
        tick(20);
        check("bounce_clk", {31'd0, clk}, 32'd1);
        check("bounce_cnt", cycle_cnt, exp_cnt);

        // Free-run for 60 cycles, dropped mid low phase
        base = cyc + 1;
        run_mode = 1'b1;
        for (int unsigned k = 0; k < 10; k++) begin
            push_ev(base + 5 + 6 * k, 1'b0, 1'b0, exp_cnt + k);
            push_ev(base + 8 + 6 * k, 1'b1, 1'b0, exp_cnt + k + 1);
        end
        exp_cnt += 10;
        tick(60);
        run_mode = 1'b0;
        tick(20);
        check("run_end_clk", {31'd0, clk}, 32'd1);
        check("run_end_cnt", cycle_cnt, exp_cnt);
        check("run_rises_vs_cnt", cycle_cnt, obs_rises);

        // Press while running is dropped
        base = cyc + 1;
        run_mode = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            push_ev(base + 5 + 6 * k, 1'b0, 1'b0, exp_cnt + k);
            push_ev(base + 8 + 6 * k, 1'b1, 1'b0, exp_cnt + k + 1);
        end
        exp_cnt += 5;
        tick(10);
        step_btn = 1'b1;
        tick(20);
        run_mode = 1'b0;
        tick(10);
        step_btn = 1'b0;
        tick(20);
        check("runpress_clk", {31'd0, clk}, 32'd1);
        check("runpress_cnt", cycle_cnt, exp_cnt);

        // Second press arriving during STEP_HI is dropped (DIV_HALF=8 instance)
        a0 = s_acks;
        r0 = s_rises;
        s_step_btn = 1'b1;
        tick(4);
        s_step_btn = 1'b0;
        tick(6);
        s_step_btn = 1'b1;
        tick(30);
        s_step_btn = 1'b0;
        tick(20);
        check("slow_acks", s_acks - a0, 32'd1);
        check("slow_rises", s_rises - r0, 32'd1);
        check("slow_cnt", s_cycle_cnt, 32'd1);

        // Asynchronous reset during STEP_LO
        base = cyc + 1;
        step_btn = 1'b1;
        push_ev(base + 6, 1'b0, 1'b1, exp_cnt);
        tick(7);
        check("steplo_clk_low", {31'd0, clk}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_clk", {31'd0, clk}, 32'd1);
        check("async_rst_cnt", cycle_cnt, 32'd0);
        check("async_rst_ack", {31'd0, step_ack}, 32'd0);
        exp_cnt = '0;
        step_btn = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(10);

        clean_press();

        tick(5);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_clk_gen.md
# step_clk_gen

CPU clock generator with run/single-step control for the single-cycle MIPS board build. Operates on `sysclk` and drives `clk`, the CPU main clock, in one of two modes:
- free-running at a fixed division of `sysclk`;
- single-step: exactly one clock period per debounced press of a board push-button.

It supersedes the fixed divider as the source of the CPU clock when the debug switch is fitted, and exports a cycle counter for the seven-segment display.

## Interface
- `DIV_HALF`, default 3: `sysclk` cycles per `clk` half-period (full period = 2·`DIV_HALF`); legal ≥ 1.
- `DEB_CYCLES`, default 4: consecutive stable samples required to accept a button level change. Use 4 in simulation and 500000 on the board; legal ≥ 1.
- `CNT_W`, default 20: width of the internal phase and debounce counters. Must hold max(`DIV_HALF`, `DEB_CYCLES`).

Ports:
- `sysclk` in 1: system clock.
- `reset` in 1: reset; asynchronous, active-high.
- `run_mode` in 1: raw switch; 1 = free-run, 0 = single-step.
- `step_btn` in 1: raw push-button; active-high, bouncy.
- `clk` out 1: CPU clock; registered.
- `step_ack` out 1: one-cycle pulse when a step is accepted.
- `cycle_cnt` out 32: number of `clk` rising edges since reset; wraps modulo 2^32.

## Operation
- **Synchronisers:** two flops each on `run_mode` and `step_btn`, giving `run_s` and `btn_s`. Reset value 0.
- **Debounce:** register `btn_db` (reset 0) plus counter `dcnt`.
  - `btn_s == btn_db`: `dcnt` ← 0.
  - Else, if `dcnt == DEB_CYCLES-1`: `btn_db` ← `btn_s` and `dcnt` ← 0.
  - Else: `dcnt` increments.
- **Step request:** `step_req = btn_db & ~btn_db_q`, where `btn_db_q` is `btn_db` delayed by one cycle.
- **FSM** (state reset to `IDLE_HI`), with phase counter `pcnt`:
  - `IDLE_HI`: `clk` = 1.
    - If `run_s` = 1: go to `RUN`, `pcnt` ← 0.
    - Else if `step_req`: go to `STEP_LO`, `clk` ← 0, `pcnt` ← 0, `step_ack` = 1.
  - `RUN`: `pcnt` counts 0..`DIV_HALF`-1. At `DIV_HALF`-1, `pcnt` ← 0 and:
    - if `clk` = 0: `clk` ← 1;
    - if `clk` = 1 and `run_s` = 1: `clk` ← 0;
    - if `clk` = 1 and `run_s` = 0: go to `IDLE_HI` (`clk` stays 1).
    - A half-period is therefore never truncated. Leaving run mode always ends on a completed high phase.
  - `STEP_LO`: after `DIV_HALF` cycles, `clk` ← 1 and go to `STEP_HI`.
  - `STEP_HI`: after `DIV_HALF` cycles, return to `IDLE_HI`.
- **Dropped inputs:** `step_req` is ignored in `RUN`, `STEP_LO` and `STEP_HI`. Requests are not queued. `run_s` changes during a step take effect only from `IDLE_HI`.
- **`cycle_cnt`:** increments on every cycle where `clk` is registered from 0 to 1, in both modes.
- **Reset values:** `clk` = 1, `step_ack` = 0, `cycle_cnt` = 0, all counters and sync flops = 0, FSM in `IDLE_HI`.
- **Reset mid-operation:** reset at any time forces all reset values immediately and asynchronously, including mid-period (`clk` snaps high).

## Timing
- **Button latency:** `step_btn` change first sampled at edge 0 → `btn_db` updates at edge `DEB_CYCLES`+1 → `clk` falls and `step_ack` pulses at edge `DEB_CYCLES`+2.
- **Glitch rejection:** a `btn_s` glitch shorter than `DEB_CYCLES` cycles produces no step.
- **Step waveform:** one step = `clk` low for `DIV_HALF` cycles, then high for `DIV_HALF` cycles. The minimum spacing between accepted steps is 2·`DIV_HALF`+1 cycles.
- **Run latency:** in `RUN`, the first falling edge of `clk` occurs `DIV_HALF`+1 edges after the edge where `run_s` is first seen as 1 in `IDLE_HI`.
- **Run waveform:** 50% duty cycle, period 2·`DIV_HALF`.
- **Register timing:** `step_ack` and `cycle_cnt` are registered and change on the same edge as the corresponding `clk` transition.

## Structure
- Shared package `cpu_clk_pkg`: FSM state enum (`IDLE_HI`, `RUN`, `STEP_LO`, `STEP_HI`) and the board default constant for `DEB_CYCLES`.
- One sub-module, `btn_debounce`: synchroniser plus debounce, parameterised by `DEB_CYCLES`, with output `btn_db`.
  - Instantiated for `step_btn`.
  - `run_mode` uses only a 2-flop synchroniser.

## Test plan
- Reset held, then released with `run_mode`=0 and no press → `clk` stays 1, `cycle_cnt`=0 for 100 cycles.
- `DEB_CYCLES`=4, `DIV_HALF`=3, clean press at edge 0 → `step_ack` and `clk` fall at edge 6, `clk` rises at edge 9, `cycle_cnt`=1, `clk` holds high afterwards.
- Bouncy press: 2-cycle high glitches, then steady high → exactly one step, no step from the glitches; the release bounce produces none.
- `run_mode`=1 for 60 cycles → `clk` period 6 cycles at 50% duty; deassert mid low phase → `clk` completes its high phase and then holds 1; `cycle_cnt` equals the number of observed rising edges.
- Press while in `RUN`, and a second press during `STEP_HI` → both are ignored and `step_ack` stays 0.
- Reset asserted during `STEP_LO` → `clk` goes to 1 and `cycle_cnt` to 0 asynchronously; the next press behaves as in scenario 2.
